// File: rtl/key_melody_recorder.sv
// -----------------------------------------------------------------------------
// key_melody_recorder
//
// Purpose:
//   Sits between the keypad scanner's locked key code and the tone decoder.
//   The block has three states:
//     IDLE : forwards the live key code, registered, to the tone decoder.
//     REC  : forwards the live key code and also run-length encodes it into
//            (code, duration) segments in an internal buffer.
//     PLAY : replays the buffer to the tone decoder in place of the keypad.
//   Durations are counted in ticks. One tick is TICK_DIV sys_clk cycles, and
//   the tick counter restarts whenever REC or PLAY is entered.
//
// Ports:
//   sys_clk     in   system clock; all logic runs on the rising edge
//   sys_rst     in   asynchronous, active-high reset
//   key_in      in   locked key code from the scanner (4'hF = no key)
//   rec_start   in   single-cycle pulse that begins recording (IDLE only)
//   play_start  in   single-cycle pulse that begins playback (IDLE only,
//                    and only when count > 0)
//   stop        in   single-cycle pulse that ends record or play; it takes
//                    priority over rec_start, which takes priority over
//                    play_start
//   key_out     out  key code to the tone decoder (4'hF = silence)
//   recording   out  high while in REC
//   playing     out  high while in PLAY
//   full        out  the buffer holds DEPTH segments
//   count       out  number of stored segments
//
// Configuration:
//   LOOP_EN     when defined, playback wraps from the last entry back to
//               entry 0 and continues until stop. When it is not defined,
//               playback makes a single pass and then returns to IDLE.
// -----------------------------------------------------------------------------
module key_melody_recorder #(
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [3:0]                 key_in,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  output logic [3:0]                 key_out,
  output logic                       recording,
  output logic                       playing,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DUR_W-1:0]  DUR_MAX    = '1;
  localparam logic [3:0]        KEY_NONE   = 4'hF;
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);

`ifdef LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [3:0]          key_out_q,   key_out_d;
  logic                recording_q, recording_d;
  logic                playing_q,   playing_d;
  logic                full_q,      full_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic [TICK_W-1:0]   tick_cnt_q,  tick_cnt_d;
  logic [3:0]          cur_code_q,  cur_code_d;
  logic [DUR_W-1:0]    dur_q,       dur_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [DUR_W-1:0]    remain_q,    remain_d;

  // The segment buffer is small and must deliver the next entry on the same
  // edge that the current one expires, so it is read combinationally.
  logic [3:0]       code_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];

  logic             tick;
  logic [DUR_W-1:0] dur_eff;
  logic             last_entry;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] rd_addr;
  logic [3:0]       rd_code;
  logic [DUR_W-1:0] rd_dur;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [3:0]       wr_code;
  logic [DUR_W-1:0] wr_dur;

  // Tick, effective duration and read-address selection
  always_comb begin
    tick = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);

    // A tick that lands on the same edge as a key change still belongs to
    // the segment that is ending, so the duration is bumped before the
    // segment is written.
    dur_eff = dur_q;
    if (tick && (dur_q != DUR_MAX)) begin
      dur_eff = dur_q + DUR_W'(1);
    end

    last_entry  = (CNT_W'(rd_ptr_q) + CNT_W'(1)) == count_q;
    rd_ptr_next = last_entry ? '0 : rd_ptr_q + PTR_W'(1);

    // In IDLE, entry 0 is presented for a possible play_start. In PLAY, the
    // entry after the current one is presented.
    rd_addr = (state_q == ST_PLAY) ? rd_ptr_next : '0;
    rd_code = code_mem[rd_addr];
    rd_dur  = dur_mem[rd_addr];
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    key_out_d  = key_out_q;
    full_d     = full_q;
    count_d    = count_q;
    cur_code_d = cur_code_q;
    dur_d      = dur_q;
    rd_ptr_d   = rd_ptr_q;
    remain_d   = remain_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[PTR_W-1:0];
    wr_code    = cur_code_q;
    wr_dur     = dur_eff;

    if (state_q == ST_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        key_out_d = key_in;
        if (stop) begin
          // stop outranks the start commands and has nothing to end here
        end else if (rec_start) begin
          state_d    = ST_REC;
          count_d    = '0;
          full_d     = 1'b0;
          cur_code_d = key_in;
          dur_d      = '0;
          tick_cnt_d = '0;
        end else if (play_start && (count_q != '0)) begin
          state_d    = ST_PLAY;
          rd_ptr_d   = '0;
          key_out_d  = rd_code;
          remain_d   = rd_dur;
          tick_cnt_d = '0;
        end
      end

      ST_REC: begin
        key_out_d = key_in;
        dur_d     = dur_eff;
        if (stop || (key_in != cur_code_q)) begin
          // Segments shorter than one tick are glitches and are dropped.
          // Once the buffer is full, further segments are discarded.
          if ((dur_eff != '0) && (count_q != COUNT_FULL)) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
            full_d  = (count_q + CNT_W'(1)) == COUNT_FULL;
          end
          cur_code_d = key_in;
          dur_d      = '0;
        end
        if (stop) begin
          state_d = ST_IDLE;
        end
      end

      ST_PLAY: begin
        if (stop) begin
          state_d   = ST_IDLE;
          key_out_d = KEY_NONE;
        end else if (tick) begin
          if (remain_q <= DUR_W'(1)) begin
            if (last_entry && !LOOP) begin
              state_d   = ST_IDLE;
              key_out_d = KEY_NONE;
            end else begin
              rd_ptr_d  = rd_ptr_next;
              key_out_d = rd_code;
              remain_d  = rd_dur;
            end
          end else begin
            remain_d = remain_q - DUR_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        key_out_d = KEY_NONE;
      end
    endcase

    recording_d = (state_d == ST_REC);
    playing_d   = (state_d == ST_PLAY);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      key_out_q   <= KEY_NONE;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
      full_q      <= 1'b0;
      count_q     <= '0;
      tick_cnt_q  <= '0;
      cur_code_q  <= KEY_NONE;
      dur_q       <= '0;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      key_out_q   <= key_out_d;
      recording_q <= recording_d;
      playing_q   <= playing_d;
      full_q      <= full_d;
      count_q     <= count_d;
      tick_cnt_q  <= tick_cnt_d;
      cur_code_q  <= cur_code_d;
      dur_q       <= dur_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
    end
  end

  // The buffer contents are not reset. Clearing count is enough to make the
  // buffer logically empty.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      code_mem[wr_addr] <= wr_code;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  assign key_out   = key_out_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign full      = full_q;
  assign count     = count_q;

endmodule
